// File: rtl/mem_mp_arb.sv
// Multi-port memory: NUM_PORTS valid/ready channels share one single-port array
// through a round-robin arbiter, with byte-enabled writes and per-port registered returns.
module mem_mp_arb #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_PORTS  = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            valid,
  input  logic [NUM_PORTS-1:0]            wt_rd,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_PORTS*WIDTH-1:0]      wdata,
  input  logic [NUM_PORTS*(WIDTH/8)-1:0]  wstrb,
  output logic [NUM_PORTS-1:0]            ready,
  output logic [NUM_PORTS*WIDTH-1:0]      rdata,
  output logic [NUM_PORTS-1:0]            rvalid,
  output logic [NUM_PORTS-1:0]            err
);

  localparam int NB  = WIDTH / 8;
  localparam int PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int PW1 = PW + 1;

  logic [PW-1:0]          ptr_r;
  logic [PW-1:0]          gnt_idx_s;
  logic                   gnt_any_s;
  logic [PW:0]            cand_s;
  int                     gnt_int_s;
  logic                   xfer_s;
  logic [NUM_PORTS-1:0]   ready_s;
  logic [ADDR_WIDTH-1:0]  g_addr_s;
  logic [WIDTH-1:0]       g_wdata_s;
  logic [NB-1:0]          g_wstrb_s;
  logic                   g_wr_s;
  logic                   in_range_s;
  logic [WIDTH-1:0]       rd_word_s;
  logic [WIDTH-1:0]       mem_r [DEPTH];
  logic [NUM_PORTS*WIDTH-1:0] rdata_r;
  logic [NUM_PORTS-1:0]   rvalid_r;
  logic [NUM_PORTS-1:0]   err_r;

  // Round-robin search: first valid port at or after the pointer, wrapping.
  always_comb begin
    gnt_idx_s = '0;
    gnt_any_s = 1'b0;
    cand_s    = '0;
    for (int j = 0; j < NUM_PORTS; j++) begin
      cand_s = {1'b0, ptr_r} + PW1'(j);
      if (cand_s >= PW1'(NUM_PORTS)) begin
        cand_s = cand_s - PW1'(NUM_PORTS);
      end else begin
        cand_s = cand_s;
      end
      if (!gnt_any_s && valid[cand_s[PW-1:0]]) begin
        gnt_any_s = 1'b1;
        gnt_idx_s = cand_s[PW-1:0];
      end else begin
        gnt_idx_s = gnt_idx_s;
      end
    end
  end

  // One-hot grant, forced low while reset is held.
  always_comb begin
    ready_s = '0;
    if (rst && gnt_any_s) begin
      ready_s[gnt_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  assign xfer_s    = rst & gnt_any_s;
  assign gnt_int_s = int'(gnt_idx_s);

  // Steer the granted port's request fields onto the shared array path.
  always_comb begin
    g_addr_s   = addr[gnt_int_s*ADDR_WIDTH +: ADDR_WIDTH];
    g_wdata_s  = wdata[gnt_int_s*WIDTH +: WIDTH];
    g_wstrb_s  = wstrb[gnt_int_s*NB +: NB];
    g_wr_s     = wt_rd[gnt_idx_s];
    in_range_s = (32'(g_addr_s) < 32'(DEPTH));
    rd_word_s  = '0;
    if (in_range_s) begin
      rd_word_s = mem_r[g_addr_s];
    end else begin
      rd_word_s = '0;
    end
  end

  // Storage array: cleared on reset, byte-masked write on an in-range write transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int d = 0; d < DEPTH; d++) begin
        mem_r[d] <= '0;
      end
    end else if (xfer_s && g_wr_s && in_range_s) begin
      for (int b = 0; b < NB; b++) begin
        if (g_wstrb_s[b]) begin
          mem_r[g_addr_s][b*8 +: 8] <= g_wdata_s[b*8 +: 8];
        end
      end
    end
  end

  // Per-port completion pulses and read data; rdata only changes on reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_r  <= '0;
      rvalid_r <= '0;
      err_r    <= '0;
    end else begin
      rvalid_r <= '0;
      err_r    <= '0;
      if (xfer_s) begin
        rvalid_r[gnt_idx_s] <= 1'b1;
        err_r[gnt_idx_s]    <= ~in_range_s;
        if (!g_wr_s) begin
          rdata_r[gnt_int_s*WIDTH +: WIDTH] <= rd_word_s;
        end
      end
    end
  end

  // Priority pointer moves just past the port that transferred.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r <= '0;
    end else if (xfer_s) begin
      ptr_r <= (gnt_idx_s == PW'(NUM_PORTS - 1)) ? '0 : gnt_idx_s + PW'(1);
    end
  end

  assign ready  = ready_s;
  assign rdata  = rdata_r;
  assign rvalid = rvalid_r;
  assign err    = err_r;

endmodule

// File: doc/mem_mp_arb.md
Name: mem_mp_arb

Overview:
- Next-generation parametrised memory block with NUM_PORTS independent requester channels, each using a valid/ready handshake.
- A round-robin arbiter grants at most one access per clock to a shared single-port array.
- Adds byte-enabled writes, a registered per-port read return (rdata/rvalid) and an out-of-range error flag.
- Sits where the single-channel memory sat; serves multiple agents/drivers concurrently.

Parameters:
- WIDTH, 32, data word width in bits; must be a multiple of 8.
- DEPTH, 32, number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
- ADDR_WIDTH, 5, address width per port.
- NUM_PORTS, 2, number of requester channels (1..8).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- valid  in  NUM_PORTS  per-port request valid.
- wt_rd  in  NUM_PORTS  per-port request type: 1 = write, 0 = read.
- addr  in  NUM_PORTS*ADDR_WIDTH  per-port address; port i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- wdata  in  NUM_PORTS*WIDTH  per-port write data.
- wstrb  in  NUM_PORTS*(WIDTH/8)  per-port byte enables; bit b enables byte b.
- ready  out  NUM_PORTS  per-port grant, combinational from valid and the priority pointer.
- rdata  out  NUM_PORTS*WIDTH  per-port registered read data.
- rvalid  out  NUM_PORTS  one-cycle pulse per completed access.
- err  out  NUM_PORTS  one-cycle pulse, coincident with rvalid, for an out-of-range access.

Behaviour:
- Reset (rst=0, asynchronous):
  - All array words cleared to 0.
  - rdata = 0, rvalid = 0, err = 0.
  - Priority pointer = 0.
  - ready is driven 0 while reset is asserted.
- Arbitration:
  - Each cycle, search ports starting at the pointer p: p, p+1, ..., wrapping modulo NUM_PORTS.
  - The first port with valid=1 gets ready=1; all other ready bits are 0.
  - ready is 0 for every port when no valid is asserted.
- Transfer occurs on a clock edge where valid[i] & ready[i] = 1. After a transfer by port k, the pointer becomes (k+1) mod NUM_PORTS. With no transfer, the pointer holds.
- Requester rule: valid and the request fields must stay stable until ready. The block does not check this.
- Write transfer:
  - Each byte b with wstrb bit b = 1 is written at that edge; other bytes are untouched.
  - wstrb = 0 is a legal no-op write.
  - Next cycle: rvalid[i] = 1; rdata[i] holds its previous value.
- Read transfer: next cycle, rdata[i] = the array word and rvalid[i] = 1. Latency is exactly 1 cycle.
- rdata[i] holds until port i's next read completes.
- Read-after-write, consecutive cycles, same address: the read sees the new data. Reads never see stale data.
- Out-of-range access (addr >= DEPTH):
  - Transfer is accepted normally.
  - Array is not modified.
  - A read returns rdata = 0.
  - err[i] = 1 and rvalid[i] = 1 next cycle.
- Throughput: one transfer per cycle total. A single requesting port may transfer every cycle (back-to-back).
- Reset asserted mid-operation:
  - Any in-flight rvalid/err is dropped.
  - Array is cleared.
  - No partial write is retained.
- NUM_PORTS = 1 degenerates to ready = valid (when not in reset); the pointer stays 0.

Test Plan:
- Reset check: hold rst=0 for 20 ns, release, read addr 5 on port 0 -> rdata = 0x0000_0000, rvalid after 1 cycle, err = 0.
- Byte-enable write:
  - Port 0 writes 0xAABBCCDD, strb 0xF to addr 3.
  - Then writes 0x11223344, strb 0x5 to addr 3.
  - Read addr 3 -> 0xAA22CC44.
- Round-robin contention:
  - Ports 0 and 1 hold valid continuously, reading addr 1 and 2.
  - ready must alternate 0,1,0,1 starting with port 0 after reset.
  - Each port receives rvalid every other cycle.
- Same-address collision:
  - Port 0 writes 0xDEADBEEF to addr 7; port 1 reads addr 7 in the same cycle.
  - Port 0 is granted first; port 1 is granted next cycle and returns 0xDEADBEEF.
- Out-of-range (DEPTH = 24):
  - Write 0x12345678 to addr 25 -> err pulses 1 cycle later, no array change.
  - Read addr 25 -> rdata = 0, err = 1.
  - Read addr 25 mod 24 = 1 -> unchanged.
- Mid-operation reset: after writing 0x55 to addr 0, assert rst low on the read-grant edge -> rvalid stays 0; after release, reading addr 0 returns 0.
